// File: rtl/famicom_pad_reader.sv
`default_nettype none
// ============================================================================
//  Module   : famicom_pad_reader
//  Purpose  : Host-side Famicom/NES pad poller. Drives latch and shift-clock
//             pulses, samples the active-low serial line and presents an
//             active-high parallel button word with a one-cycle valid strobe.
//  Option   : FAMICOM_PAD_PRESENT_EN adds one extra shift to detect an
//             absent pad (line left pulled high after the last bit).
//  Revision : 1.0 - initial release
// ============================================================================
module famicom_pad_reader #(
  parameter int HALF_PERIOD = 300,
  parameter int NUM_BITS    = 8,
  parameter int AUTO_POLL   = 1,
  parameter int POLL_PERIOD = 833333
) (
  input  logic                sys_clk,
  input  logic                rst,
  input  logic                start,
  input  logic                famicom_data,
  output logic                famicom_latch,
  output logic                famicom_pulse,
  output logic [NUM_BITS-1:0] buttons,
  output logic                valid,
  output logic                busy,
  output logic                pad_present
);

  localparam int c_CW = $clog2(2 * HALF_PERIOD);
  localparam int c_BW = $clog2(NUM_BITS + 1);
  localparam int c_PW = $clog2(POLL_PERIOD + 1);

  localparam logic [c_CW-1:0] c_HALF_M1 = c_CW'(HALF_PERIOD - 1);
  localparam logic [c_CW-1:0] c_FULL_M1 = c_CW'(2 * HALF_PERIOD - 1);
  localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);
  localparam logic [c_BW-1:0] c_LAST_BIT = c_BW'(NUM_BITS - 1);
  localparam logic [c_BW-1:0] c_BIT_ONE  = c_BW'(1);

  localparam logic [2:0] c_ST_IDLE     = 3'd0;
  localparam logic [2:0] c_ST_LATCH    = 3'd1;
  localparam logic [2:0] c_ST_PULSE_HI = 3'd2;
  localparam logic [2:0] c_ST_PULSE_LO = 3'd3;
  localparam logic [2:0] c_ST_DONE     = 3'd5;
`ifdef FAMICOM_PAD_PRESENT_EN
  localparam logic [2:0] c_ST_EXTRA      = 3'd4;
  localparam logic [c_CW-1:0] c_HALF     = c_CW'(HALF_PERIOD);
  localparam logic [2:0] c_ST_AFTER_BITS = c_ST_EXTRA;
`else
  localparam logic [2:0] c_ST_AFTER_BITS = c_ST_DONE;
`endif

  logic                r_ds_meta;
  logic                r_ds;
  logic [2:0]          r_state;
  logic [c_CW-1:0]     r_cnt;
  logic [c_BW-1:0]     r_bit;
  logic [NUM_BITS-1:0] r_shift;
  logic [NUM_BITS-1:0] r_buttons;
  logic                r_latch;
  logic                r_pulse;
  logic                r_valid;
  logic                r_busy;

  logic                w_auto_tick;
  logic                w_req;
  logic                w_cnt_zero;
  logic                w_sample;
  logic                w_pulse_nxt;
  logic [2:0]          w_state_nxt;
  logic [c_CW-1:0]     w_cnt_nxt;
  logic [c_BW-1:0]     w_bit_nxt;
  logic [NUM_BITS-1:0] w_shift_nxt;

  // Free-running poll timer; keeps counting whatever the FSM is doing.
  generate
    if (AUTO_POLL != 0) begin : g_auto_poll
      localparam logic [c_PW-1:0] c_POLL_LAST = c_PW'(POLL_PERIOD - 1);
      localparam logic [c_PW-1:0] c_POLL_ONE  = c_PW'(1);
      logic [c_PW-1:0] r_poll_cnt;

      always_ff @(posedge sys_clk) begin
        if (!rst) begin
          r_poll_cnt <= '0;
        end else if (r_poll_cnt == c_POLL_LAST) begin
          r_poll_cnt <= '0;
        end else begin
          r_poll_cnt <= r_poll_cnt + c_POLL_ONE;
        end
      end

      assign w_auto_tick = (r_poll_cnt == c_POLL_LAST);
    end else begin : g_no_auto_poll
      assign w_auto_tick = 1'b0;
    end
  endgenerate

  assign w_req      = start | w_auto_tick;
  assign w_cnt_zero = (r_cnt == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_sample    = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        if (w_req) begin
          w_state_nxt = c_ST_LATCH;
          w_cnt_nxt   = c_FULL_M1;
          w_bit_nxt   = '0;
        end
      end
      c_ST_LATCH: begin
        if (w_cnt_zero) begin
          w_sample = 1'b1;
          if (NUM_BITS == 1) begin
            w_state_nxt = c_ST_AFTER_BITS;
            w_cnt_nxt   = c_FULL_M1;
          end else begin
            w_state_nxt = c_ST_PULSE_HI;
            w_cnt_nxt   = c_HALF_M1;
            w_bit_nxt   = c_BIT_ONE;
          end
        end else begin
          w_cnt_nxt = r_cnt - c_CNT_ONE;
        end
      end
      c_ST_PULSE_HI: begin
        if (w_cnt_zero) begin
          w_state_nxt = c_ST_PULSE_LO;
          w_cnt_nxt   = c_HALF_M1;
        end else begin
          w_cnt_nxt = r_cnt - c_CNT_ONE;
        end
      end
      c_ST_PULSE_LO: begin
        if (w_cnt_zero) begin
          w_sample = 1'b1;
          if (r_bit == c_LAST_BIT) begin
            w_state_nxt = c_ST_AFTER_BITS;
            w_cnt_nxt   = c_FULL_M1;
          end else begin
            w_state_nxt = c_ST_PULSE_HI;
            w_cnt_nxt   = c_HALF_M1;
            w_bit_nxt   = r_bit + c_BIT_ONE;
          end
        end else begin
          w_cnt_nxt = r_cnt - c_CNT_ONE;
        end
      end
`ifdef FAMICOM_PAD_PRESENT_EN
      // One high/low pair in a single state: pulse is high for the upper half count.
      c_ST_EXTRA: begin
        if (w_cnt_zero) begin
          w_state_nxt = c_ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt - c_CNT_ONE;
        end
      end
`endif
      c_ST_DONE: begin
        w_state_nxt = c_ST_IDLE;
      end
      default: begin
        w_state_nxt = c_ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_shift_nxt = r_shift;
    for (int i = 0; i < NUM_BITS; i++) begin
      if (w_sample && (r_bit == c_BW'(i))) begin
        w_shift_nxt[i] = r_ds;
      end
    end
  end

`ifdef FAMICOM_PAD_PRESENT_EN
  assign w_pulse_nxt = (w_state_nxt == c_ST_PULSE_HI) ||
                       ((w_state_nxt == c_ST_EXTRA) && (w_cnt_nxt >= c_HALF));
`else
  assign w_pulse_nxt = (w_state_nxt == c_ST_PULSE_HI);
`endif

  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      r_ds_meta <= 1'b1;
      r_ds      <= 1'b1;
    end else begin
      r_ds_meta <= famicom_data;
      r_ds      <= r_ds_meta;
    end
  end

  // Pad-facing and status outputs are registered from the next state so they never glitch.
  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      r_state   <= c_ST_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_buttons <= '0;
      r_latch   <= 1'b0;
      r_pulse   <= 1'b0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_latch <= (w_state_nxt == c_ST_LATCH);
      r_pulse <= w_pulse_nxt;
      r_valid <= (w_state_nxt == c_ST_DONE);
      r_busy  <= (w_state_nxt != c_ST_IDLE);
      if (w_state_nxt == c_ST_DONE) begin
`ifdef FAMICOM_PAD_PRESENT_EN
        r_buttons <= r_ds ? '0 : ~w_shift_nxt;
`else
        r_buttons <= ~w_shift_nxt;
`endif
      end
    end
  end

`ifdef FAMICOM_PAD_PRESENT_EN
  logic r_pad_present;

  // The extra bit is low only when a real pad is driving the line.
  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      r_pad_present <= 1'b0;
    end else if (w_state_nxt == c_ST_DONE) begin
      r_pad_present <= ~r_ds;
    end
  end

  assign pad_present = r_pad_present;
`else
  assign pad_present = 1'b1;
`endif

  assign famicom_latch = r_latch;
  assign famicom_pulse = r_pulse;
  assign buttons       = r_buttons;
  assign valid         = r_valid;
  assign busy          = r_busy;

endmodule
`default_nettype wire

// File: doc/famicom_pad_reader.md
Name: famicom_pad_reader

Overview:
- Host-side Famicom/NES controller poller; the initiator end of the famicom_latch/famicom_pulse/famicom_data serial link consumed by the daphne top.
- Generates the latch and clock pulses, samples the serial data line and presents a parallel, active-high button word to the rest of the design.
- Polls on request or periodically, and flags each completed read with a one-cycle valid strobe.

Parameters:
- HALF_PERIOD, 300, sys_clk cycles per half bit period (H); must be >= 4.
- NUM_BITS, 8, bits shifted per poll (8 = NES pad, 16 = SNES-style pad).
- AUTO_POLL, 1, 1 = poll automatically every POLL_PERIOD cycles; 0 = poll on start only.
- POLL_PERIOD, 833333, sys_clk cycles between automatic poll requests; must be > 2*H*NUM_BITS+2.

Ports:
- sys_clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- start  in  1  single-cycle poll request; ignored while busy.
- famicom_data  in  1  serial data from pad; active-low (low = pressed); asynchronous.
- famicom_latch  out  1  latch strobe to pad, active-high.
- famicom_pulse  out  1  shift clock to pad, active-high.
- buttons  out  NUM_BITS  last completed read; bit i = 1 means button i pressed; bit 0 = first bit shifted (A).
- valid  out  1  one-cycle strobe when buttons updates.
- busy  out  1  high from request acceptance to the valid cycle inclusive.
- pad_present  out  1  see Optional Feature; constant 1 when the feature is compiled out.

Behaviour:
- Reset (rst=0 at a sys_clk edge): famicom_latch=0, famicom_pulse=0, buttons=0, valid=0, busy=0, pad_present=0 (feature in) / 1 (feature out); FSM=IDLE; all counters=0. Reset during a poll aborts it immediately; no valid is produced.
- famicom_data passes through a 2-flop synchronizer (ds). Every sample uses ds.
- Request = start | auto_tick.
  - auto_tick is a free-running counter 0..POLL_PERIOD-1 that pulses at wrap; it runs in every state.
  - A request arriving while busy is dropped, not queued.
  - start and auto_tick in the same cycle give one poll.
- FSM states and transitions:
  - IDLE: latch=0, pulse=0. On a request, go to LATCH; busy=1 from the next cycle.
  - LATCH: latch=1 for 2H cycles. In the last cycle, sample ds into shift bit 0. Then go to PULSE_HI, or to DONE if NUM_BITS=1.
  - PULSE_HI: pulse=1 for H cycles, then go to PULSE_LO.
  - PULSE_LO: pulse=0 for H cycles. In the last cycle, sample ds into the next shift bit. Go to PULSE_HI if bits remain; otherwise go to EXTRA (feature in) or DONE.
  - DONE: buttons <= ~shift; valid=1 for one cycle; busy stays 1 in this cycle; next state is IDLE.
- Latency: with the request seen in cycle 0, latch is high in cycles 1..2H. valid occurs in cycle 2H*NUM_BITS+1 (feature out) or 2H*(NUM_BITS+1)+1 (feature in).
- A half-period counter reloads to H-1 on each state entry; 2H for LATCH is counted as 2H-1 down to 0.
- The bit counter is 0..NUM_BITS-1 and sized $clog2(NUM_BITS+1).
- buttons holds its value between polls. valid never asserts on two consecutive cycles.
- latch and pulse are never high in the same cycle.

Optional Feature:
- Macro: FAMICOM_PAD_PRESENT_EN.
- Compiled in: after the last data bit, state EXTRA performs one further PULSE_HI/PULSE_LO pair (2H cycles) and samples ds at its end.
  - A connected standard pad drives the line low after its last bit; an absent pad leaves it pulled high.
  - In DONE: pad_present <= ~ds_extra; if the pad is absent, buttons <= 0 instead of ~shift.
- Compiled out: no EXTRA state; pad_present is tied to 1; latency is as given above for feature out.

Test Plan:
- H=4, N=8, AUTO_POLL=0; pad model returns wire bits 0,1,1,1,1,1,1,0 (A and Right pressed); pulse start -> latch high 8 cycles, then 7 pulses of 4 high/4 low; valid exactly at cycle 65 (feature out); buttons=8'h81.
- Same setup; pulse start again at cycles 10 and 64 -> no second latch and no extra valid; next start after idle -> one poll.
- AUTO_POLL=1, POLL_PERIOD=100, H=4, N=8 -> latch rises every 100 cycles; a start on an auto_tick cycle -> still one poll.
- Assert rst=0 during pulse 3 -> next cycle latch=0, pulse=0, busy=0, buttons=0; no valid; the next start gives a full correct read.
- FAMICOM_PAD_PRESENT_EN defined, data line held high (no pad) -> 9 pulses, valid at cycle 73, pad_present=0, buttons=0; pad driving 9th bit low with wire 0xFE pattern -> pad_present=1, buttons=8'h01.
- N=16, H=4, alternating wire pattern 0,1,0,1,... -> valid at cycle 129, buttons=16'h5555.
